data_mem_sized: RTL

Parametrised successor to the MIPS data memory: byte-addressed, big-endian storage with a valid/ready request port, byte/half/word accesses, signed or unsigned load extension, configurable wait states and an error response for misaligned, out-of-range or reserved accesses. Sits between the MEM stage and its backing store, and serves lw/lh/lhu/lb/lbu/sw/sh/sb with the stall-capable handshake the pipeline needs.

---
 rtl/data_mem_pkg.sv | 40 ++++
 rtl/data_mem_sized_if.sv | 26 ++
 rtl/mem_load_extend.sv | 22 ++
 rtl/data_mem_sized.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types for the sized data memory: access-size encodings, FSM states,
// the latched request payload and a byte-count helper.
package data_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic              write;
    size_e             size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Reserved size reports zero bytes; it is rejected by the error check anyway.
  function automatic logic [2:0] size_bytes(size_e s);
    case (s)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response port of the sized data memory (MEM stage side is master).
interface data_mem_sized_if;
  import data_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_load_extend.sv
// Right-justifies big-endian load bytes and applies sign or zero extension.
module mem_load_extend
  import data_mem_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  size_e             size,
  input  logic              uns,
  output logic [DATA_W-1:0] data_c
);

  // raw[31:24] is the byte at the access address, raw[23:16] the next, and so on.
  always_comb begin
    data_c = '0;
    case (size)
      SZ_BYTE: data_c = uns ? {24'h0, raw[31:24]} : {{24{raw[31]}}, raw[31:24]};
      SZ_HALF: data_c = uns ? {16'h0, raw[31:16]} : {{16{raw[31]}}, raw[31:16]};
      SZ_WORD: data_c = raw;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with valid/ready requests, sized
// accesses, programmable wait states and an error response.
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_sized_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_e            state;
  state_e            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  req_t              lat;
  req_t              req_in;
  req_t              cur;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              accept;
  logic              commit;
  logic              err_c;
  logic [2:0]        nbytes;
  logic [EXT_W-1:0]  last_c;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] load_c;
  logic [7:0]        mem [DEPTH_BYTES];

  assign req_in = '{write: bus.req_write,
                    size:  size_e'(bus.req_size),
                    uns:   bus.req_unsigned,
                    addr:  bus.req_addr,
                    wdata: bus.req_wdata};

  // ready_q is only ever high in IDLE, so accept implies IDLE.
  assign accept = bus.req_valid && ready_q;

  // Next state; with zero wait states the commit edge is the accept edge,
  // so the live request is used instead of the latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    cur        = lat;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cur = req_in;
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            commit     = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Range check runs on 33 bits so addresses near 2^32 cannot wrap to a small end.
  assign nbytes = size_bytes(cur.size);
  assign last_c = {1'b0, cur.addr} + EXT_W'(nbytes) - EXT_W'(1);
  assign err_c  = (cur.size == SZ_RSVD)
               || (cur.size == SZ_HALF && cur.addr[0])
               || (cur.size == SZ_WORD && cur.addr[1:0] != 2'b00)
               || (last_c >= EXT_W'(DEPTH_BYTES));

  assign idx = cur.addr[IDX_W-1:0];
  assign raw = {mem[idx], mem[idx + IDX_W'(1)], mem[idx + IDX_W'(2)], mem[idx + IDX_W'(3)]};

  mem_load_extend u_ext (
    .raw    (raw),
    .size   (cur.size),
    .uns    (cur.uns),
    .data_c (load_c)
  );

  // Storage is not reset; a committed write survives a later reset.
  always_ff @(posedge clk) begin
    if (commit && cur.write && !err_c) begin
      case (cur.size)
        SZ_WORD: begin
          mem[idx]              <= cur.wdata[31:24];
          mem[idx + IDX_W'(1)]  <= cur.wdata[23:16];
          mem[idx + IDX_W'(2)]  <= cur.wdata[15:8];
          mem[idx + IDX_W'(3)]  <= cur.wdata[7:0];
        end
        SZ_HALF: begin
          mem[idx]              <= cur.wdata[15:8];
          mem[idx + IDX_W'(1)]  <= cur.wdata[7:0];
        end
        SZ_BYTE: mem[idx] <= cur.wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat         <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ready_q     <= (state_next == ST_IDLE);
      rsp_valid_q <= commit;
      if (accept) begin
        lat <= req_in;
      end
      if (commit) begin
        rsp_err_q   <= err_c;
        rsp_rdata_q <= (err_c || cur.write) ? '0 : load_c;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
